// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/forwarding controller.
// All signals are level-valued every cycle; there is no valid/ready handshake on this bundle.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] id_ex_rd;
  logic              id_ex_mem_read;
  logic              id_ex_multicycle;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_reg_write;
  logic [REG_AW-1:0] mem_wb_rd;
  logic              mem_wb_reg_write;
  logic              branch_taken;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              id_ex_bubble;
  logic              ex_mem_bubble;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, id_ex_rd,
           id_ex_mem_read, id_ex_multicycle, ex_mem_rd, ex_mem_reg_write,
           mem_wb_rd, mem_wb_reg_write, branch_taken,
    input  forward_a, forward_b, pc_write, if_id_write, id_ex_write, id_ex_bubble,
           ex_mem_bubble, if_id_flush, id_ex_flush, ex_mem_flush, mc_busy,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, id_ex_rd,
           id_ex_mem_read, id_ex_multicycle, ex_mem_rd, ex_mem_reg_write,
           mem_wb_rd, mem_wb_reg_write, branch_taken,
    output forward_a, forward_b, pc_write, if_id_write, id_ex_write, id_ex_bubble,
           ex_mem_bubble, if_id_flush, id_ex_flush, ex_mem_flush, mc_busy,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: operand forwarding,
// load-use stall, multi-cycle EX freeze, taken-branch flush and perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic                   dbg_state_o
);

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

  localparam int              MC_W      = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
  localparam logic [MC_W-1:0] MC_LOAD   = MC_W'((MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0);
  localparam bit              MC_EN     = (MC_LATENCY > 1);
  localparam bit              BR_IN_MEM = (BR_STAGE == 3);

  state_t            state_q, state_d;
  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              freeze;
  logic              load_use;
  logic              pc_write_c;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] exm_rd,
                                         input logic              exm_we,
                                         input logic [REG_AW-1:0] wb_rd,
                                         input logic              wb_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (exm_we && (exm_rd != '0) && (exm_rd == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign bus.forward_a = fwd_sel(bus.ex_rs1, bus.ex_mem_rd, bus.ex_mem_reg_write,
                                 bus.mem_wb_rd, bus.mem_wb_reg_write);
  assign bus.forward_b = fwd_sel(bus.ex_rs2, bus.ex_mem_rd, bus.ex_mem_reg_write,
                                 bus.mem_wb_rd, bus.mem_wb_reg_write);

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    freeze   = 1'b0;
    case (state_q)
      RUN: begin
        if (!bus.branch_taken && bus.id_ex_multicycle && MC_EN) begin
          freeze   = 1'b1;
          mc_cnt_d = MC_LOAD;
          state_d  = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (bus.branch_taken) begin
          mc_cnt_d = '0;
          state_d  = RUN;
        end else if (mc_cnt_q != '0) begin
          freeze   = 1'b1;
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end else begin
          // Release cycle: the op leaves EX at the next edge without re-triggering.
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    load_use = (state_q == RUN) && !freeze && !bus.branch_taken &&
               bus.id_ex_mem_read && (bus.id_ex_rd != '0) &&
               ((bus.id_uses_rs1 && (bus.id_rs1 == bus.id_ex_rd)) ||
                (bus.id_uses_rs2 && (bus.id_rs2 == bus.id_ex_rd)));

    pc_write_c        = !(freeze || load_use);
    bus.pc_write      = pc_write_c;
    bus.if_id_write   = pc_write_c;
    bus.id_ex_write   = !freeze;
    bus.id_ex_bubble  = load_use;
    bus.ex_mem_bubble = freeze;
    bus.if_id_flush   = bus.branch_taken;
    bus.id_ex_flush   = bus.branch_taken;
    bus.ex_mem_flush  = bus.branch_taken && BR_IN_MEM;
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write_c && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (bus.branch_taken && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.mc_busy      = (state_q == MC_WAIT);
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the combinational
// selects plus hand-written sequences for stalls, freeze, flush, reset and saturation.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;

  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_multicycle;
  logic       ex_mem_reg_write, mem_wb_reg_write, branch_taken;
  logic       dbg_a, dbg_b;

  int total = 0;
  int bad   = 0;

  // A: MC_LATENCY=4, BR_STAGE=3, CNT_W=16.  B: MC_LATENCY=1, BR_STAGE=2, CNT_W=2.
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus_b ();

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(4), .BR_STAGE(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .dbg_state_o(dbg_a));
  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(1), .BR_STAGE(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state_o(dbg_b));

  assign bus_a.id_rs1 = id_rs1;                     assign bus_b.id_rs1 = id_rs1;
  assign bus_a.id_rs2 = id_rs2;                     assign bus_b.id_rs2 = id_rs2;
  assign bus_a.id_uses_rs1 = id_uses_rs1;           assign bus_b.id_uses_rs1 = id_uses_rs1;
  assign bus_a.id_uses_rs2 = id_uses_rs2;           assign bus_b.id_uses_rs2 = id_uses_rs2;
  assign bus_a.ex_rs1 = ex_rs1;                     assign bus_b.ex_rs1 = ex_rs1;
  assign bus_a.ex_rs2 = ex_rs2;                     assign bus_b.ex_rs2 = ex_rs2;
  assign bus_a.id_ex_rd = id_ex_rd;                 assign bus_b.id_ex_rd = id_ex_rd;
  assign bus_a.id_ex_mem_read = id_ex_mem_read;     assign bus_b.id_ex_mem_read = id_ex_mem_read;
  assign bus_a.id_ex_multicycle = id_ex_multicycle; assign bus_b.id_ex_multicycle = id_ex_multicycle;
  assign bus_a.ex_mem_rd = ex_mem_rd;               assign bus_b.ex_mem_rd = ex_mem_rd;
  assign bus_a.ex_mem_reg_write = ex_mem_reg_write; assign bus_b.ex_mem_reg_write = ex_mem_reg_write;
  assign bus_a.mem_wb_rd = mem_wb_rd;               assign bus_b.mem_wb_rd = mem_wb_rd;
  assign bus_a.mem_wb_reg_write = mem_wb_reg_write; assign bus_b.mem_wb_reg_write = mem_wb_reg_write;
  assign bus_a.branch_taken = branch_taken;         assign bus_b.branch_taken = branch_taken;

  // {fwd_a, fwd_b, pc_wr, ifid_wr, idex_wr, idex_bub, exmem_bub, ifid_fl, idex_fl, exmem_fl}
  logic [11:0] out_a, out_b;
  assign out_a = {bus_a.forward_a, bus_a.forward_b, bus_a.pc_write, bus_a.if_id_write,
                  bus_a.id_ex_write, bus_a.id_ex_bubble, bus_a.ex_mem_bubble,
                  bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.ex_mem_flush};
  assign out_b = {bus_b.forward_a, bus_b.forward_b, bus_b.pc_write, bus_b.if_id_write,
                  bus_b.id_ex_write, bus_b.id_ex_bubble, bus_b.ex_mem_bubble,
                  bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.ex_mem_flush};

  typedef struct {
    logic [4:0]  id_rs1, id_rs2;
    logic        u1, u2;
    logic [4:0]  ex_rs1, ex_rs2, id_ex_rd;
    logic        mem_read;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_we;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_we;
    logic        br;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[14];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [4:0] r1, r2, input logic u1, u2,
                               input logic [4:0] e1, e2, xrd, input logic mr,
                               input logic [4:0] mrd, input logic mwe,
                               input logic [4:0] wrd, input logic wwe,
                               input logic br, input logic [11:0] exp);
    vec_t v;
    v.id_rs1 = r1; v.id_rs2 = r2; v.u1 = u1; v.u2 = u2;
    v.ex_rs1 = e1; v.ex_rs2 = e2; v.id_ex_rd = xrd; v.mem_read = mr;
    v.ex_mem_rd = mrd; v.ex_mem_we = mwe; v.mem_wb_rd = wrd; v.mem_wb_we = wwe;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  // driver tasks
  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; id_ex_rd = '0; id_ex_mem_read = 1'b0;
    id_ex_multicycle = 1'b0; ex_mem_rd = '0; ex_mem_reg_write = 1'b0;
    mem_wb_rd = '0; mem_wb_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; id_ex_rd = v.id_ex_rd;
    id_ex_mem_read = v.mem_read; id_ex_multicycle = 1'b0;
    ex_mem_rd = v.ex_mem_rd; ex_mem_reg_write = v.ex_mem_we;
    mem_wb_rd = v.mem_wb_rd; mem_wb_reg_write = v.mem_wb_we; branch_taken = v.br;
  endtask

  task automatic load_use_rs2();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    #2 reset = 1'b1;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = mkv(0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 12'h0E0);
    vecs[1]  = mkv(0,0,0,0, 5,0,0,0, 5,1, 5,1, 0, 12'h8E0);
    vecs[2]  = mkv(0,0,0,0, 5,0,0,0, 0,1, 5,1, 0, 12'h4E0);
    vecs[3]  = mkv(0,0,0,0, 0,9,0,0, 9,0, 9,1, 0, 12'h1E0);
    vecs[4]  = mkv(0,0,0,0, 3,3,0,0, 3,1, 0,0, 0, 12'hAE0);
    vecs[5]  = mkv(0,0,0,0, 0,0,0,0, 0,0, 0,1, 0, 12'h0E0);
    vecs[6]  = mkv(0,0,0,0, 4,6,0,0, 6,1, 4,1, 0, 12'h6E0);
    vecs[7]  = mkv(0,7,0,1, 0,0,7,1, 0,0, 0,0, 0, 12'h030);
    vecs[8]  = mkv(7,0,1,0, 0,0,7,1, 0,0, 0,0, 0, 12'h030);
    vecs[9]  = mkv(7,0,0,0, 0,0,7,1, 0,0, 0,0, 0, 12'h0E0);
    vecs[10] = mkv(0,0,1,0, 0,0,0,1, 0,0, 0,0, 0, 12'h0E0);
    vecs[11] = mkv(7,0,1,0, 0,0,7,0, 0,0, 0,0, 0, 12'h0E0);
    vecs[12] = mkv(7,0,1,0, 0,0,7,1, 0,0, 0,0, 1, 12'h0E7);
    vecs[13] = mkv(0,0,0,0, 2,0,0,0, 2,1, 0,0, 1, 12'h8E7);

    reset = 1'b0;
    idle();
    #12;
    chk("rst_busy", bus_a.mc_busy, 0);
    chk("rst_stall", bus_a.stall_cycles, 0);
    chk("rst_flush", bus_a.flush_events, 0);
    chk("rst_pc_write", bus_a.pc_write, 1);
    @(negedge clk);
    reset = 1'b1;

    // Vector table; B resolves branches in EX so it never flushes EX/MEM.
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec_a[%0d]", i), out_a, vecs[i].exp);
      chk($sformatf("vec_b[%0d]", i), out_b, vecs[i].exp & 12'hFFE);
    end
    next_cycle();
    idle();
    @(negedge clk);
    chk("tbl_stall_a", bus_a.stall_cycles, 2);
    chk("tbl_flush_a", bus_a.flush_events, 2);
    chk("tbl_stall_b", bus_b.stall_cycles, 2);
    chk("tbl_flush_b", bus_b.flush_events, 2);

    // Load-use costs exactly one cycle.
    do_reset();
    next_cycle();
    load_use_rs2();
    @(negedge clk);
    chk("lu_pc_write", bus_a.pc_write, 0);
    chk("lu_if_id_write", bus_a.if_id_write, 0);
    chk("lu_bubble", bus_a.id_ex_bubble, 1);
    next_cycle();
    id_ex_mem_read = 1'b0;
    @(negedge clk);
    chk("lu_after_pc_write", bus_a.pc_write, 1);
    chk("lu_after_bubble", bus_a.id_ex_bubble, 0);
    chk("lu_stall_cnt", bus_a.stall_cycles, 1);

    // Multi-cycle op with MC_LATENCY=4: three freeze cycles then release.
    do_reset();
    next_cycle();
    id_ex_multicycle = 1'b1;
    @(negedge clk);
    chk("mc0_pc_write", bus_a.pc_write, 0);
    chk("mc0_id_ex_write", bus_a.id_ex_write, 0);
    chk("mc0_ex_mem_bubble", bus_a.ex_mem_bubble, 1);
    chk("mc0_busy", bus_a.mc_busy, 0);
    chk("mc0_b_no_freeze", bus_b.pc_write, 1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      load_use_rs2();
      @(negedge clk);
      chk($sformatf("mc%0d_busy", c), bus_a.mc_busy, 1);
      chk($sformatf("mc%0d_dbg", c), dbg_a, 1);
      chk($sformatf("mc%0d_pc_write", c), bus_a.pc_write, (c == 3) ? 1 : 0);
      chk($sformatf("mc%0d_ex_mem_bubble", c), bus_a.ex_mem_bubble, (c == 3) ? 0 : 1);
      chk($sformatf("mc%0d_lu_suppressed", c), bus_a.id_ex_bubble, 0);
    end
    next_cycle();
    idle();
    @(negedge clk);
    chk("mc4_busy", bus_a.mc_busy, 0);
    chk("mc4_stall_cnt", bus_a.stall_cycles, 3);

    // Taken branch during the second MC_WAIT cycle aborts the freeze.
    do_reset();
    next_cycle();
    id_ex_multicycle = 1'b1;
    next_cycle();
    next_cycle();
    branch_taken = 1'b1;
    @(negedge clk);
    chk("brmc_flushes", out_a[2:0], 3'b111);
    chk("brmc_pc_write", bus_a.pc_write, 1);
    chk("brmc_ex_mem_bubble", bus_a.ex_mem_bubble, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("brmc_busy_after", bus_a.mc_busy, 0);
    chk("brmc_pc_after", bus_a.pc_write, 1);
    chk("brmc_flush_cnt", bus_a.flush_events, 1);
    chk("brmc_stall_cnt", bus_a.stall_cycles, 2);

    // Branch together with a multi-cycle op in RUN: flush wins, no MC_WAIT.
    do_reset();
    next_cycle();
    id_ex_multicycle = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    chk("brrun_pc_write", bus_a.pc_write, 1);
    chk("brrun_id_ex_write", bus_a.id_ex_write, 1);
    chk("brrun_flushes", out_a[2:0], 3'b111);
    next_cycle();
    idle();
    @(negedge clk);
    chk("brrun_busy", bus_a.mc_busy, 0);
    chk("brrun_stall_cnt", bus_a.stall_cycles, 0);

    // Asynchronous reset in the middle of MC_WAIT.
    do_reset();
    next_cycle();
    id_ex_multicycle = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rmc_busy_before", bus_a.mc_busy, 1);
    chk("rmc_stall_before", bus_a.stall_cycles, 1);
    #1;
    reset = 1'b0;
    idle();
    #1;
    chk("rmc_busy", bus_a.mc_busy, 0);
    chk("rmc_stall", bus_a.stall_cycles, 0);
    chk("rmc_flush", bus_a.flush_events, 0);
    chk("rmc_pc_write", bus_a.pc_write, 1);
    #2 reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rmc_after_busy", bus_a.mc_busy, 0);
    chk("rmc_after_pc_write", bus_a.pc_write, 1);

    // Five load-use stalls: 2-bit counter saturates at 3, 16-bit counts 5.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      load_use_rs2();
      next_cycle();
      idle();
    end
    @(negedge clk);
    chk("sat_stall_b", bus_b.stall_cycles, 3);
    chk("sat_stall_a", bus_a.stall_cycles, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
